// File: rtl/msp430_trace_buffer.sv
// Instruction trace ring buffer for the MSP430 debug environment.
// Captures one 40-bit record per decoded instruction while tracing is
// enabled, supports a PC trigger with a post-trigger capture window, and
// drains records oldest-first through a one-cycle-latency pop port.
module msp430_trace_buffer #(
    parameter int ADDR_W = 4
) (
    input  logic              mclk,
    input  logic              reset_n,
    input  logic              decode,
    input  logic [15:0]       pc,
    input  logic [15:0]       ir,
    input  logic              irq_detect,
    input  logic              trace_en,
    input  logic              trig_en,
    input  logic [15:0]       trig_pc,
    input  logic [ADDR_W-1:0] post_trig,
    input  logic              clear,
    input  logic              rd_req,
    output logic              rd_ack,
    output logic [39:0]       rd_data,
    output logic [ADDR_W:0]   count,
    output logic [1:0]        state,
    output logic              overflow
);

    localparam int DEPTH = 1 << ADDR_W;

    localparam logic [ADDR_W:0]   CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W:0]   CNT_FULL = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W-1:0] PTR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [6:0]        CYC_MAX  = 7'd127;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_RUN    = 2'b01,
        ST_POST   = 2'b10,
        ST_FROZEN = 2'b11
    } state_e;

    state_e              state_q;
    logic [ADDR_W-1:0]   wr_ptr_q;
    logic [ADDR_W-1:0]   rd_ptr_q;
    logic [ADDR_W:0]     count_q;
    logic                overflow_q;
    logic [6:0]          cyc_q;
    logic [ADDR_W-1:0]   post_q;
    logic                rd_ack_q;
    logic [39:0]         rd_data_q;
    logic [39:0]         mem [DEPTH];

    logic        trig_hit;
    logic        wr_en;
    logic        rd_en;
    logic        buf_full;
    logic        buf_empty;
    logic [39:0] rec;

    // Writes only while actively recording; a trace_en drop wins over a decode.
    assign trig_hit  = trig_en && (pc == trig_pc);
    assign wr_en     = decode && trace_en && ((state_q == ST_RUN) || (state_q == ST_POST));
    assign rd_en     = rd_req && ((state_q == ST_IDLE) || (state_q == ST_FROZEN));
    assign buf_full  = (count_q == CNT_FULL);
    assign buf_empty = (count_q == '0);
    assign rec       = {irq_detect, cyc_q, pc, ir};

    // Cycles since the previous decode; 0 until the first decode means "unknown".
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge mclk or negedge reset_n) begin
        if (!reset_n) begin
            cyc_q <= '0;
        end else if (decode) begin
            cyc_q <= 7'd1;
        end else if ((cyc_q != '0) && (cyc_q != CYC_MAX)) begin
            cyc_q <= cyc_q + 7'd1;
        end
    end

    // Capture-control FSM with trigger and post-trigger down-counter.
    always_ff @(posedge mclk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            post_q  <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (trace_en) state_q <= ST_RUN;
                end
                ST_RUN: begin
                    if (!trace_en) begin
                        state_q <= ST_IDLE;
                    end else if (decode && trig_hit) begin
                        if (post_trig == '0) begin
                            state_q <= ST_FROZEN;
                        end else begin
                            state_q <= ST_POST;
                            post_q  <= post_trig;
                        end
                    end
                end
                ST_POST: begin
                    if (!trace_en) begin
                        state_q <= ST_IDLE;
                    end else if (decode) begin
                        post_q <= post_q - PTR_ONE;
                        if (post_q == PTR_ONE) state_q <= ST_FROZEN;
                    end
                end
                default: begin
                    if (!trace_en) state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Ring pointers, occupancy and sticky overflow; clear beats any access.
    always_ff @(posedge mclk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else if (clear) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else if (wr_en) begin
            wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (buf_full) begin
                rd_ptr_q   <= rd_ptr_q + PTR_ONE;
                overflow_q <= 1'b1;
            end else begin
                count_q <= count_q + CNT_ONE;
            end
        end else if (rd_en && !buf_empty) begin
            rd_ptr_q <= rd_ptr_q + PTR_ONE;
            count_q  <= count_q - CNT_ONE;
        end
    end

    // Pop response: one-cycle ack, zero data when empty, data held otherwise.
    always_ff @(posedge mclk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ack_q  <= 1'b0;
            rd_data_q <= '0;
        end else begin
            rd_ack_q <= rd_en && !clear;
            if (rd_en && !clear) begin
                rd_data_q <= buf_empty ? 40'd0 : mem[rd_ptr_q];
            end
        end
    end

    // Record storage.
    // NOTE: the RAM array has no reset; stale entries are never observable because count gates every read.
    always_ff @(posedge mclk) begin
        if (wr_en && !clear) begin
            mem[wr_ptr_q] <= rec;
        end
    end

    assign rd_ack   = rd_ack_q;
    assign rd_data  = rd_data_q;
    assign count    = count_q;
    assign state    = state_q;
    assign overflow = overflow_q;

endmodule
